// File: rtl/sa_frame_ctrl_pkg.sv
// Shared types and constants for the UART-fed systolic array frame controller.
// The CHECK state exists only when SA_FRAME_CTRL_CHECKSUM_EN is defined.
package sa_frame_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam logic [7:0] NAK_BYTE     = 8'hEE;
  localparam int         RESULT_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_ACT = 3'd1,
    LOAD_WGT = 3'd2,
    COMPUTE  = 3'd3,
`ifdef SA_FRAME_CTRL_CHECKSUM_EN
    SEND     = 3'd4,
    CHECK    = 3'd5
`else
    SEND     = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/sa_frame_ctrl_if.sv
// UART byte-level signals between the frame controller (master) and the UART (slave).
// rx_valid is a one-cycle strobe with rx_data; tx_start is a one-cycle request
// that may only be raised while tx_busy is low, and tx_busy rises the cycle after.
interface sa_frame_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (input rx_valid, rx_data, tx_busy, output tx_start, tx_data);
  modport slave  (output rx_valid, rx_data, tx_busy, input tx_start, tx_data);
endinterface

// File: rtl/sa_frame_ctrl_tx_seq.sv
// Transmit sequencer: sends up to four bytes MSB-first from a loaded word,
// pacing tx_start against tx_busy, and pulses done once the last byte has gone.
module sa_frame_tx_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_count,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        done
);

  logic [31:0] shreg;
  logic [2:0]  remaining;
  logic        active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      remaining <= '0;
      active    <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      done      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      if (load) begin
        shreg     <= load_data;
        remaining <= load_count;
        active    <= 1'b1;
      end else if (active && !tx_busy && !tx_start) begin
        // tx_busy only rises the cycle after tx_start, so the !tx_start term
        // prevents a second request in the gap.
        if (remaining != 3'd0) begin
          tx_start  <= 1'b1;
          tx_data   <= shreg[31:24];
          shreg     <= {shreg[23:0], 8'h00};
          remaining <= remaining - 3'd1;
        end else begin
          done   <= 1'b1;
          active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sa_frame_ctrl.sv
// Frame controller: sync byte, 4 activation bytes, 4 weight bytes, a timed
// compute burst, then results sent back. SA_FRAME_CTRL_CHECKSUM_EN adds an XOR check byte.
module sa_frame_ctrl
  import sa_frame_pkg::*;
#(
  parameter int COMPUTE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  sa_frame_ctrl_if.master        uart,
  output logic [31:0]            activation_stream,
  output logic [31:0]            weight_stream,
  output logic                   array_clr,
  output logic                   array_en,
  input  logic [15:0]            final_result_0,
  input  logic [15:0]            final_result_1,
  output logic                   led_red,
  output logic                   led_blue,
  output logic                   led_green,
  output logic                   busy,
  output logic                   err,
  output state_t                 state
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [1:0]    byte_cnt;
  logic [TW-1:0] timer;
  logic [7:0]    cyc_cnt;
  logic          tx_load;
  logic [31:0]   tx_load_data;
  logic [2:0]    tx_load_count;
  logic          tx_done;
`ifdef SA_FRAME_CTRL_CHECKSUM_EN
  logic [7:0]    chk;
`endif

  // Status flags decode straight from the state register.
  assign busy     = (state != IDLE);
  assign led_red  = (state == LOAD_ACT) || (state == LOAD_WGT);
  assign led_blue = (state == COMPUTE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      activation_stream <= '0;
      weight_stream     <= '0;
      array_clr         <= 1'b0;
      array_en          <= 1'b0;
      led_green         <= 1'b0;
      err               <= 1'b0;
      byte_cnt          <= '0;
      timer             <= '0;
      cyc_cnt           <= '0;
      tx_load           <= 1'b0;
      tx_load_data      <= '0;
      tx_load_count     <= '0;
`ifdef SA_FRAME_CTRL_CHECKSUM_EN
      chk               <= '0;
`endif
    end else begin
      array_clr <= 1'b0;
      tx_load   <= 1'b0;
      case (state)
        IDLE: begin
          if (uart.rx_valid && uart.rx_data == SYNC_BYTE) begin
            state     <= LOAD_ACT;
            array_clr <= 1'b1;
            err       <= 1'b0;
            led_green <= 1'b0;
            byte_cnt  <= '0;
            timer     <= '0;
`ifdef SA_FRAME_CTRL_CHECKSUM_EN
            chk       <= '0;
`endif
          end
        end
        LOAD_ACT, LOAD_WGT: begin
          if (uart.rx_valid) begin
            timer    <= '0;
            byte_cnt <= byte_cnt + 2'd1;
`ifdef SA_FRAME_CTRL_CHECKSUM_EN
            chk      <= chk ^ uart.rx_data;
`endif
            if (state == LOAD_ACT) activation_stream <= {activation_stream[23:0], uart.rx_data};
            else                   weight_stream     <= {weight_stream[23:0], uart.rx_data};
            if (byte_cnt == 2'd3) begin
              byte_cnt <= '0;
              if (state == LOAD_ACT) begin
                state <= LOAD_WGT;
              end else begin
`ifdef SA_FRAME_CTRL_CHECKSUM_EN
                state    <= CHECK;
`else
                state    <= COMPUTE;
                array_en <= 1'b1;
                cyc_cnt  <= '0;
`endif
              end
            end
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
`ifdef SA_FRAME_CTRL_CHECKSUM_EN
        CHECK: begin
          if (uart.rx_valid) begin
            if (uart.rx_data == chk) begin
              state    <= COMPUTE;
              array_en <= 1'b1;
              cyc_cnt  <= '0;
            end else begin
              state         <= IDLE;
              err           <= 1'b1;
              tx_load       <= 1'b1;
              tx_load_data  <= {NAK_BYTE, 24'h000000};
              tx_load_count <= 3'd1;
            end
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
`endif
        COMPUTE: begin
          if (uart.rx_valid) err <= 1'b1;
          cyc_cnt <= cyc_cnt + 8'd1;
          if (cyc_cnt == 8'(COMPUTE_CYCLES - 1)) array_en <= 1'b0;
          // One settle cycle after the last enable so the final accumulate is captured.
          if (cyc_cnt == 8'(COMPUTE_CYCLES)) begin
            state         <= SEND;
            tx_load       <= 1'b1;
            tx_load_data  <= {final_result_0, final_result_1};
            tx_load_count <= 3'(RESULT_BYTES);
          end
        end
        SEND: begin
          if (uart.rx_valid) err <= 1'b1;
          if (tx_done) begin
            state     <= IDLE;
            led_green <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sa_frame_tx_seq u_tx_seq (
    .clk        (clk),
    .reset      (reset),
    .load       (tx_load),
    .load_data  (tx_load_data),
    .load_count (tx_load_count),
    .tx_busy    (uart.tx_busy),
    .tx_start   (uart.tx_start),
    .tx_data    (uart.tx_data),
    .done       (tx_done)
  );

endmodule

// File: tb/tb_sa_frame_ctrl.sv
// Directed bench for sa_frame_ctrl with a 10-cycle UART busy model.
// Covers SA_FRAME_CTRL_CHECKSUM_EN builds as well as the default build.
module tb_sa_frame_ctrl;
  import sa_frame_pkg::*;

  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] activation_stream, weight_stream;
  logic        array_clr, array_en;
  logic [15:0] final_result_0 = 16'h1234;
  logic [15:0] final_result_1 = 16'hABCD;
  logic        led_red, led_blue, led_green, busy, err;
  state_t      dbg_state;

  int pass_n = 0;
  int chk_n  = 0;

  sa_frame_ctrl_if uart ();

  sa_frame_ctrl #(.COMPUTE_CYCLES(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk (clk), .reset (reset), .uart (uart.master),
    .activation_stream (activation_stream), .weight_stream (weight_stream),
    .array_clr (array_clr), .array_en (array_en),
    .final_result_0 (final_result_0), .final_result_1 (final_result_1),
    .led_red (led_red), .led_blue (led_blue), .led_green (led_green),
    .busy (busy), .err (err), .state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // UART busy model and monitors (sole owners of their variables)
  int         busy_cnt = 0;
  int         en_cycles = 0;
  int         clr_cnt = 0;
  int         viol = 0;
  logic [7:0] tx_q[$];
  assign uart.tx_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (!reset) busy_cnt = 0;
    else begin
      if (uart.tx_start) begin
        tx_q.push_back(uart.tx_data);
        if (uart.tx_busy) viol++;
        busy_cnt = 10;
      end else if (busy_cnt > 0) busy_cnt--;
      if (array_en) en_cycles++;
      if (array_clr) clr_cnt++;
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); uart.rx_valid = 1'b1; uart.rx_data = b;
    @(negedge clk); uart.rx_valid = 1'b0; uart.rx_data = 8'h00;
  endtask

  task automatic send_payload(input logic [31:0] act, input logic [31:0] wgt);
    send_byte(SYNC_BYTE);
    for (int i = 3; i >= 0; i--) send_byte(act[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(wgt[i*8 +: 8]);
  endtask

  task automatic send_frame(input logic [31:0] act, input logic [31:0] wgt);
    logic [7:0] x;
    x = act[31:24] ^ act[23:16] ^ act[15:8] ^ act[7:0] ^
        wgt[31:24] ^ wgt[23:16] ^ wgt[15:8] ^ wgt[7:0];
    send_payload(act, wgt);
`ifdef SA_FRAME_CTRL_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (dbg_state != IDLE && n < 3000) begin @(negedge clk); n++; end
    chk_n++;
    if (dbg_state !== IDLE) $display("FAIL %s_idle_wait: state %0d after %0d cycles, want IDLE", name, dbg_state, n);
    else pass_n++;
  endtask

  // scoreboard: compare tx bytes captured since base against exp_q
  task automatic check_tx(input string name, input int base, input logic [7:0] exp_q[$]);
    chk_n++;
    if (tx_q.size() - base !== exp_q.size())
      $display("FAIL %s_tx_count: got %0d want %0d", name, tx_q.size() - base, exp_q.size());
    else begin
      pass_n++;
      for (int i = 0; i < exp_q.size(); i++) begin
        chk_n++;
        if (tx_q[base+i] !== exp_q[i]) $display("FAIL %s_tx_byte%0d: got %h want %h", name, i, tx_q[base+i], exp_q[i]);
        else pass_n++;
      end
    end
  endtask

  task automatic test_reset();
    uart.rx_valid = 1'b0; uart.rx_data = 8'h00;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_n++; if (dbg_state !== IDLE) $display("FAIL rst_state: got %0d want 0", dbg_state); else pass_n++;
    chk_n++; if ({uart.tx_start, uart.tx_data} !== 9'h0) $display("FAIL rst_tx: got %h want 0", {uart.tx_start, uart.tx_data}); else pass_n++;
    chk_n++; if ({activation_stream, weight_stream} !== 64'h0) $display("FAIL rst_streams: got %h want 0", {activation_stream, weight_stream}); else pass_n++;
    chk_n++; if ({array_clr, array_en, led_red, led_blue, led_green, busy, err} !== 7'h0)
      $display("FAIL rst_flags: got %b want 0000000", {array_clr, array_en, led_red, led_blue, led_green, busy, err}); else pass_n++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ignore();
    int clr0 = clr_cnt;
    send_byte(8'h55); send_byte(8'h00);
    repeat (3) @(negedge clk);
    chk_n++; if (dbg_state !== IDLE) $display("FAIL ignore_state: got %0d want IDLE", dbg_state); else pass_n++;
    chk_n++; if ({err, busy, led_red} !== 3'b000) $display("FAIL ignore_flags: err/busy/red got %b want 000", {err, busy, led_red}); else pass_n++;
    chk_n++; if (clr_cnt - clr0 !== 0) $display("FAIL ignore_clr: got %0d pulses want 0", clr_cnt - clr0); else pass_n++;
  endtask

  task automatic test_frame();
    int base = tx_q.size();
    int en0 = en_cycles, clr0 = clr_cnt, v0 = viol;
    final_result_0 = 16'h1234; final_result_1 = 16'hABCD;
    send_byte(SYNC_BYTE);
    chk_n++; if ({led_red, busy} !== 2'b11) $display("FAIL frame_load_flags: red/busy got %b want 11", {led_red, busy}); else pass_n++;
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    for (int i = 1; i <= 4; i++) send_byte(8'(i * 16));
`ifdef SA_FRAME_CTRL_CHECKSUM_EN
    chk_n++; if (dbg_state !== CHECK) $display("FAIL frame_after8_state: got %0d want CHECK", dbg_state); else pass_n++;
    send_byte(8'h44);
`else
    chk_n++; if (dbg_state !== COMPUTE) $display("FAIL frame_after8_state: got %0d want COMPUTE", dbg_state); else pass_n++;
`endif
    chk_n++; if ({led_blue, led_red} !== 2'b10) $display("FAIL frame_compute_leds: blue/red got %b want 10", {led_blue, led_red}); else pass_n++;
    wait_idle("frame");
    chk_n++; if (activation_stream !== 32'h01020304) $display("FAIL frame_act: got %h want 01020304", activation_stream); else pass_n++;
    chk_n++; if (weight_stream !== 32'h10203040) $display("FAIL frame_wgt: got %h want 10203040", weight_stream); else pass_n++;
    chk_n++; if (en_cycles - en0 !== 4) $display("FAIL frame_en_cycles: got %0d want 4", en_cycles - en0); else pass_n++;
    chk_n++; if (clr_cnt - clr0 !== 1) $display("FAIL frame_clr: got %0d want 1", clr_cnt - clr0); else pass_n++;
    check_tx("frame", base, '{8'h12, 8'h34, 8'hAB, 8'hCD});
    chk_n++; if (viol - v0 !== 0) $display("FAIL frame_start_while_busy: got %0d want 0", viol - v0); else pass_n++;
    chk_n++; if ({led_green, err, busy} !== 3'b100) $display("FAIL frame_end_flags: green/err/busy got %b want 100", {led_green, err, busy}); else pass_n++;
  endtask

  task automatic test_timeout();
    int base;
    send_byte(SYNC_BYTE); send_byte(8'h01); send_byte(8'h02);
    chk_n++; if (led_green !== 1'b0) $display("FAIL timeout_green_clr: got %b want 0", led_green); else pass_n++;
    repeat (TIMEOUT - 10) @(negedge clk);
    chk_n++; if (dbg_state !== LOAD_ACT) $display("FAIL timeout_early: got %0d want LOAD_ACT", dbg_state); else pass_n++;
    repeat (20) @(negedge clk);
    chk_n++; if (dbg_state !== IDLE) $display("FAIL timeout_state: got %0d want IDLE", dbg_state); else pass_n++;
    chk_n++; if (err !== 1'b1) $display("FAIL timeout_err: got %b want 1", err); else pass_n++;
    chk_n++; if (activation_stream !== 32'h03040102) $display("FAIL timeout_partial: got %h want 03040102", activation_stream); else pass_n++;
    base = tx_q.size();
    send_frame(32'h01020304, 32'h10203040);
    wait_idle("timeout_recover");
    chk_n++; if (err !== 1'b0) $display("FAIL timeout_err_cleared: got %b want 0", err); else pass_n++;
    check_tx("timeout_recover", base, '{8'h12, 8'h34, 8'hAB, 8'hCD});
  endtask

  task automatic test_rx_in_compute();
    int base = tx_q.size();
    int clr0 = clr_cnt;
    send_frame(32'hCAFE0001, 32'h00000002);
    send_byte(SYNC_BYTE);
    wait_idle("rx_compute");
    chk_n++; if (err !== 1'b1) $display("FAIL rx_compute_err: got %b want 1", err); else pass_n++;
    chk_n++; if (clr_cnt - clr0 !== 1) $display("FAIL rx_compute_no_restart: clr got %0d want 1", clr_cnt - clr0); else pass_n++;
    check_tx("rx_compute", base, '{8'h12, 8'h34, 8'hAB, 8'hCD});
    repeat (5) @(negedge clk);
    chk_n++; if (busy !== 1'b0) $display("FAIL rx_compute_busy: got %b want 0", busy); else pass_n++;
  endtask

  task automatic test_back_to_back();
    int base = tx_q.size();
    int en0 = en_cycles;
    final_result_0 = 16'h0F0F; final_result_1 = 16'hF00F;
    send_frame(32'hDEADBEEF, 32'h00FF00FF);
    wait_idle("b2b");
    chk_n++; if (err !== 1'b0) $display("FAIL b2b_err_cleared: got %b want 0", err); else pass_n++;
    chk_n++; if ({activation_stream, weight_stream} !== 64'hDEADBEEF_00FF00FF)
      $display("FAIL b2b_streams: got %h want deadbeef00ff00ff", {activation_stream, weight_stream}); else pass_n++;
    check_tx("b2b", base, '{8'h0F, 8'h0F, 8'hF0, 8'h0F});
    chk_n++; if (en_cycles - en0 !== 4) $display("FAIL b2b_en_cycles: got %0d want 4", en_cycles - en0); else pass_n++;
  endtask

  task automatic test_reset_in_send();
    int base = tx_q.size();
    int n = 0;
    final_result_0 = 16'h5555; final_result_1 = 16'hAAAA;
    send_frame(32'h11111111, 32'h22222222);
    while (tx_q.size() - base < 2 && n < 500) begin @(negedge clk); n++; end
    chk_n++; if (tx_q.size() - base !== 2) $display("FAIL rsend_reach2: got %0d bytes want 2", tx_q.size() - base); else pass_n++;
    reset = 1'b0;
    #1;
    chk_n++; if ({uart.tx_start, uart.tx_data, array_en, array_clr, busy, err, led_red, led_blue, led_green} !== 16'h0)
      $display("FAIL rsend_outputs: got %h want 0", {uart.tx_start, uart.tx_data, array_en, array_clr, busy, err, led_red, led_blue, led_green}); else pass_n++;
    chk_n++; if ({activation_stream, weight_stream} !== 64'h0) $display("FAIL rsend_streams: got %h want 0", {activation_stream, weight_stream}); else pass_n++;
    chk_n++; if (dbg_state !== IDLE) $display("FAIL rsend_state: got %0d want IDLE", dbg_state); else pass_n++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    chk_n++; if (tx_q.size() - base !== 2) $display("FAIL rsend_no_more_tx: got %0d bytes want 2", tx_q.size() - base); else pass_n++;
  endtask

`ifdef SA_FRAME_CTRL_CHECKSUM_EN
  task automatic test_checksum_bad();
    int base = tx_q.size();
    int en0 = en_cycles;
    send_payload(32'h01020304, 32'h10203040);
    send_byte(8'h00);
    repeat (40) @(negedge clk);
    check_tx("chk_bad", base, '{NAK_BYTE});
    chk_n++; if (en_cycles - en0 !== 0) $display("FAIL chk_bad_en: got %0d want 0", en_cycles - en0); else pass_n++;
    chk_n++; if ({err, dbg_state} !== {1'b1, IDLE}) $display("FAIL chk_bad_state: err/state got %b/%0d want 1/IDLE", err, dbg_state); else pass_n++;
  endtask
`endif

  initial begin
    test_reset();
    test_ignore();
    test_frame();
    test_timeout();
    test_rx_in_compute();
    test_back_to_back();
    test_reset_in_send();
`ifdef SA_FRAME_CTRL_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
